mem_port_arbiter: RTL and testbench

- Shares the core's single memory bus between instruction fetch (IFU) and load/store (LSU).
- Sits between the IFU/LSU and the DPI-backed memory model.
- Serialises requests: one outstanding transaction at a time.
- Per-transaction response timeout reports a hung memory instead of stalling the core forever.

---
 rtl/mem_port_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between instruction fetch (IFU)
// and load/store (LSU). One transaction is outstanding at a time.
// A per-transaction timeout turns a hung memory into an error response.
//
// Handshake semantics: a request transfers on the rising edge where
// *_req_valid and *_req_ready are both high. A requester holds valid and its
// fields until it sees ready. On the bus side, mem_req_valid holds with
// stable fields until mem_req_ready is seen high at a rising edge.
// Responses are single-cycle pulses with no back-pressure.
//
// Optional build macro: ARB_ROUND_ROBIN_EN. When defined, simultaneous
// requests go to the requester that did not own the bus last. When
// undefined, LSU always wins over IFU.
module mem_port_arbiter #(
  parameter int TIMEOUT = 256,  // cycles allowed in WAIT; 0 disables
  parameter int CNT_W   = 9     // 2**CNT_W must exceed TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rsp_valid,
  output logic [31:0] ifu_rsp_data,
  output logic        ifu_rsp_err,
  // load/store port
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_rsp_valid,
  output logic [31:0] lsu_rsp_data,
  output logic        lsu_rsp_err,
  // memory bus
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  // debug: current FSM state (0 IDLE, 1 REQ, 2 WAIT)
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;
  localparam logic TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LIMIT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_owner;
  logic [31:0]      r_addr;
  logic             r_wen;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wmask;
  logic [CNT_W-1:0] r_cnt;

  logic             r_ifu_rsp_valid;
  logic [31:0]      r_ifu_rsp_data;
  logic             r_ifu_rsp_err;
  logic             r_lsu_rsp_valid;
  logic [31:0]      r_lsu_rsp_data;
  logic             r_lsu_rsp_err;

  logic             w_grant_ifu;
  logic             w_grant_lsu;
  logic             w_prefer_lsu;
  logic             w_timeout;
  logic             w_rsp_fire;
  logic             w_rsp_err;
  logic [31:0]      w_rsp_data;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_owner;

  // Remember who owned the bus last so a tie goes to the other requester.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_owner <= OWN_IFU;
    end else if (w_grant_ifu || w_grant_lsu) begin
      r_last_owner <= w_grant_lsu;
    end
  end

  assign w_prefer_lsu = (r_last_owner == OWN_IFU);
`else
  assign w_prefer_lsu = 1'b1;
`endif

  // Final WAIT cycle before an error response is forced.
  assign w_timeout = TO_EN && (r_cnt == CNT_LIMIT);

  // Next-state, grant and response-fire decisions.
  always_comb begin
    w_next_state = r_state;
    w_grant_ifu  = 1'b0;
    w_grant_lsu  = 1'b0;
    w_rsp_fire   = 1'b0;
    w_rsp_err    = 1'b0;
    w_rsp_data   = 32'h0;
    case (r_state)
      S_IDLE: begin
        w_grant_lsu = lsu_req_valid && (!ifu_req_valid || w_prefer_lsu);
        w_grant_ifu = ifu_req_valid && !w_grant_lsu;
        if (w_grant_lsu || w_grant_ifu) begin
          w_next_state = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response arriving on the last timeout cycle still wins.
        if (mem_rsp_valid) begin
          w_next_state = S_IDLE;
          w_rsp_fire   = 1'b1;
          w_rsp_data   = (r_owner == OWN_LSU && r_wen) ? 32'h0 : mem_rsp_data;
        end else if (w_timeout) begin
          w_next_state = S_IDLE;
          w_rsp_fire   = 1'b1;
          w_rsp_err    = 1'b1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latch the granted request; fetches carry no write fields.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_owner <= OWN_IFU;
      r_addr  <= 32'h0;
      r_wen   <= 1'b0;
      r_wdata <= 32'h0;
      r_wmask <= 4'h0;
    end else if (w_grant_lsu) begin
      r_owner <= OWN_LSU;
      r_addr  <= lsu_addr;
      r_wen   <= lsu_wen;
      r_wdata <= lsu_wdata;
      r_wmask <= lsu_wmask;
    end else if (w_grant_ifu) begin
      r_owner <= OWN_IFU;
      r_addr  <= ifu_addr;
      r_wen   <= 1'b0;
      r_wdata <= 32'h0;
      r_wmask <= 4'h0;
    end
  end

  // Timeout counter: cleared on bus acceptance, counts every WAIT cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (r_state == S_REQ && mem_req_ready) begin
      r_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // One-cycle response pulse routed to the current owner only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ifu_rsp_valid <= 1'b0;
      r_ifu_rsp_data  <= 32'h0;
      r_ifu_rsp_err   <= 1'b0;
      r_lsu_rsp_valid <= 1'b0;
      r_lsu_rsp_data  <= 32'h0;
      r_lsu_rsp_err   <= 1'b0;
    end else begin
      r_ifu_rsp_valid <= w_rsp_fire && (r_owner == OWN_IFU);
      r_ifu_rsp_data  <= (w_rsp_fire && r_owner == OWN_IFU) ? w_rsp_data : 32'h0;
      r_ifu_rsp_err   <= w_rsp_fire && (r_owner == OWN_IFU) && w_rsp_err;
      r_lsu_rsp_valid <= w_rsp_fire && (r_owner == OWN_LSU);
      r_lsu_rsp_data  <= (w_rsp_fire && r_owner == OWN_LSU) ? w_rsp_data : 32'h0;
      r_lsu_rsp_err   <= w_rsp_fire && (r_owner == OWN_LSU) && w_rsp_err;
    end
  end

  assign ifu_req_ready = w_grant_ifu;
  assign lsu_req_ready = w_grant_lsu;

  assign mem_req_valid = (r_state == S_REQ);
  assign mem_addr      = r_addr;
  assign mem_wen       = r_wen;
  assign mem_wdata     = r_wdata;
  assign mem_wmask     = r_wmask;

  assign ifu_rsp_valid = r_ifu_rsp_valid;
  assign ifu_rsp_data  = r_ifu_rsp_data;
  assign ifu_rsp_err   = r_ifu_rsp_err;
  assign lsu_rsp_valid = r_lsu_rsp_valid;
  assign lsu_rsp_data  = r_lsu_rsp_data;
  assign lsu_rsp_err   = r_lsu_rsp_err;

  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: acts as both requesters and the memory,
// and predicts every grant, bus request and response at transaction level.
module tb_mem_port_arbiter;

  localparam int TO = 8;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_data;
  logic        ifu_rsp_err;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rsp_data;
  logic        lsu_rsp_err;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [1:0]  o_dbg_state;

  mem_port_arbiter #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- reference model state ----------------
  // rsp_dly: response driven rsp_dly+1 cycles after bus acceptance; -1 = never.
  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          rdy_dly;
    int          rsp_dly;
    logic [31:0] rdata;
  } req_t;

  req_t ifu_q[$];
  req_t lsu_q[$];
  bit   grant_log[$];     // 1 = LSU granted, 0 = IFU granted

  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;

  bit          out_valid = 0;   // a granted transaction has no response yet
  bit          out_lsu = 0;
  req_t        out_req;
  int          g_cyc = 0;
  bit          acc = 0;
  int          rdy_left = 0;
  int          rsp_drive_cyc = -1;
  int          exp_rsp_cyc = -1;
  bit          exp_err = 0;
  logic [31:0] exp_data = 32'h0;
  int          late_cyc = -1;
  bit          last_lsu = 0;
  bit          noise_en = 0;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic req_t mk_ifu(input logic [31:0] a, input int rdy, input int rsp, input logic [31:0] rd);
    req_t r;
    r.addr = a; r.wen = 1'b0; r.wdata = 32'h0; r.wmask = 4'h0;
    r.rdy_dly = rdy; r.rsp_dly = rsp; r.rdata = rd;
    return r;
  endfunction

  function automatic req_t mk_lsu(input logic [31:0] a, input logic w, input logic [31:0] wd,
                                  input logic [3:0] m, input int rdy, input int rsp, input logic [31:0] rd);
    req_t r;
    r.addr = a; r.wen = w; r.wdata = wd; r.wmask = m;
    r.rdy_dly = rdy; r.rsp_dly = rsp; r.rdata = rd;
    return r;
  endfunction

  function automatic req_t rand_req(input bit is_lsu);
    int d;
    d = int'($urandom_range(0, 10));
    if (d == 10) d = -1;
    if (is_lsu)
      return mk_lsu($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                    int'($urandom_range(0, 3)), d, $urandom);
    return mk_ifu($urandom, int'($urandom_range(0, 3)), d, $urandom);
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic tick();
    bit exp_iv, exp_lv, exp_mv, win_lsu, exp_ir, exp_lr;
    @(negedge clk);
    cyc++;

    // responses due this cycle
    exp_iv = out_valid && acc && !out_lsu && (cyc == exp_rsp_cyc);
    exp_lv = out_valid && acc &&  out_lsu && (cyc == exp_rsp_cyc);
    check("ifu_rsp_valid", 32'(ifu_rsp_valid), 32'(exp_iv));
    check("lsu_rsp_valid", 32'(lsu_rsp_valid), 32'(exp_lv));
    if (exp_iv) begin
      check("ifu_rsp_data", ifu_rsp_data, exp_data);
      check("ifu_rsp_err", 32'(ifu_rsp_err), 32'(exp_err));
    end
    if (exp_lv) begin
      check("lsu_rsp_data", lsu_rsp_data, exp_data);
      check("lsu_rsp_err", 32'(lsu_rsp_err), 32'(exp_err));
    end
    if (exp_iv || exp_lv) out_valid = 0;

    // memory side
    exp_mv = out_valid && !acc && (cyc > g_cyc);
    check("mem_req_valid", 32'(mem_req_valid), 32'(exp_mv));
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = $urandom;
    if (exp_mv && mem_req_valid) begin
      check("mem_addr", mem_addr, out_req.addr);
      check("mem_wen", 32'(mem_wen), out_lsu ? 32'(out_req.wen) : 32'h0);
      check("mem_wdata", mem_wdata, out_lsu ? out_req.wdata : 32'h0);
      check("mem_wmask", 32'(mem_wmask), out_lsu ? 32'(out_req.wmask) : 32'h0);
      if (rdy_left > 0) begin
        rdy_left--;
      end else begin
        mem_req_ready = 1'b1;
        acc = 1;
        if (out_req.rsp_dly >= 0 && out_req.rsp_dly <= TO - 1) begin
          rsp_drive_cyc = cyc + 1 + out_req.rsp_dly;
          exp_rsp_cyc   = rsp_drive_cyc + 1;
          exp_err       = 0;
          exp_data      = (out_lsu && out_req.wen) ? 32'h0 : out_req.rdata;
        end else begin
          rsp_drive_cyc = -1;
          exp_rsp_cyc   = cyc + 1 + TO;
          exp_err       = 1;
          exp_data      = 32'h0;
          late_cyc      = exp_rsp_cyc;
        end
      end
    end
    if (out_valid && acc && cyc == rsp_drive_cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = out_req.rdata;
    end else if (cyc == late_cyc) begin
      mem_rsp_valid = 1'b1;           // late response after a timeout
    end else if (noise_en && !(out_valid && acc) && $urandom_range(0, 3) == 0) begin
      mem_rsp_valid = 1'b1;           // stray response outside WAIT
    end

    // requesters
    ifu_req_valid = (ifu_q.size() > 0);
    ifu_addr      = ifu_req_valid ? ifu_q[0].addr : 32'h0;
    lsu_req_valid = (lsu_q.size() > 0);
    lsu_addr      = lsu_req_valid ? lsu_q[0].addr  : 32'h0;
    lsu_wen       = lsu_req_valid ? lsu_q[0].wen   : 1'b0;
    lsu_wdata     = lsu_req_valid ? lsu_q[0].wdata : 32'h0;
    lsu_wmask     = lsu_req_valid ? lsu_q[0].wmask : 4'h0;
    #1;
`ifdef ARB_ROUND_ROBIN_EN
    win_lsu = lsu_req_valid && (!ifu_req_valid || !last_lsu);
`else
    win_lsu = lsu_req_valid;
`endif
    exp_lr = !out_valid && win_lsu;
    exp_ir = !out_valid && ifu_req_valid && !win_lsu;
    check("ifu_req_ready", 32'(ifu_req_ready), 32'(exp_ir));
    check("lsu_req_ready", 32'(lsu_req_ready), 32'(exp_lr));
    if (exp_lr || exp_ir) begin
      out_valid     = 1;
      out_lsu       = exp_lr;
      out_req       = exp_lr ? lsu_q.pop_front() : ifu_q.pop_front();
      g_cyc         = cyc;
      acc           = 0;
      rdy_left      = out_req.rdy_dly;
      rsp_drive_cyc = -1;
      exp_rsp_cyc   = -1;
      last_lsu      = exp_lr;
      grant_log.push_back(exp_lr);
    end
  endtask

  // Run until every queued request has been answered (bounded).
  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((ifu_q.size() > 0 || lsu_q.size() > 0 || out_valid) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(ifu_q.size() + lsu_q.size() + int'(out_valid)), 32'h0);
    tick();
    tick();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    ifu_req_valid = 1'b0; ifu_addr = 32'h0;
    lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hFFFF_FFFF;
    ifu_q.delete(); lsu_q.delete();
    out_valid = 0; acc = 0; late_cyc = -1; rsp_drive_cyc = -1; exp_rsp_cyc = -1; last_lsu = 0;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    check("rst_ifu_req_ready", 32'(ifu_req_ready), 32'h0);
    check("rst_lsu_req_ready", 32'(lsu_req_ready), 32'h0);
    check("rst_ifu_rsp_valid", 32'(ifu_rsp_valid), 32'h0);
    check("rst_ifu_rsp_data", ifu_rsp_data, 32'h0);
    check("rst_ifu_rsp_err", 32'(ifu_rsp_err), 32'h0);
    check("rst_lsu_rsp_valid", 32'(lsu_rsp_valid), 32'h0);
    check("rst_lsu_rsp_data", lsu_rsp_data, 32'h0);
    check("rst_lsu_rsp_err", 32'(lsu_rsp_err), 32'h0);
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wen", 32'(mem_wen), 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_wmask", 32'(mem_wmask), 32'h0);
    check("rst_state_idle", 32'(o_dbg_state), 32'h0);
    rst = 1'b1;
  endtask

  task automatic check_grants(input string tag, input bit exp_seq[$]);
    check({tag, "_count"}, 32'(grant_log.size()), 32'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size() && i < grant_log.size(); i++)
      check({tag, "_owner"}, 32'(grant_log[i]), 32'(exp_seq[i]));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit exp_seq[$];
    rst = 1'b0;
    ifu_req_valid = 1'b0; ifu_addr = 32'h0;
    lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    repeat (2) @(negedge clk);
    apply_reset();

    // single fetch: memory ready at once, responds 2 cycles after acceptance
    ifu_q.push_back(mk_ifu(32'h8000_0000, 0, 1, 32'h0000_0413));
    drain("single_fetch", 50);

    // store held on the bus for several cycles before acceptance
    lsu_q.push_back(mk_lsu(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 3, 2, 32'hCAFE_F00D));
    drain("store", 50);

    // load
    lsu_q.push_back(mk_lsu(32'h8000_2004, 1'b0, 32'h0, 4'h0, 1, 0, 32'h1357_9BDF));
    drain("load", 50);

    // lone fetch, then three simultaneous pairs
    ifu_q.push_back(mk_ifu(32'h8000_0004, 0, 0, 32'h0000_0013));
    drain("pre_pair_fetch", 50);
    grant_log.delete();
    for (int i = 0; i < 3; i++) begin
      lsu_q.push_back(mk_lsu(32'h9000_0000 + 32'(i * 4), 1'(i & 1), 32'h1111_0000 + 32'(i), 4'h3, 0, 1, 32'hA0A0_0000 + 32'(i)));
      ifu_q.push_back(mk_ifu(32'h8000_0100 + 32'(i * 4), 0, 1, 32'hB0B0_0000 + 32'(i)));
      drain("pair", 80);
    end
    exp_seq = '{1, 0, 1, 0, 1, 0};
    check_grants("pairs", exp_seq);

    // LSU keeps requesting while IFU waits
    grant_log.delete();
    lsu_q.push_back(mk_lsu(32'h9000_0100, 1'b0, 32'h0, 4'hF, 0, 0, 32'h2222_0001));
    lsu_q.push_back(mk_lsu(32'h9000_0104, 1'b0, 32'h0, 4'hF, 0, 0, 32'h2222_0002));
    ifu_q.push_back(mk_ifu(32'h8000_0200, 0, 0, 32'h3333_0001));
    drain("lsu_stream", 100);
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = '{1, 0, 1};
`else
    exp_seq = '{1, 1, 0};
`endif
    check_grants("lsu_stream", exp_seq);

    // timeout: memory never answers; late response dropped; next fetch ok
    ifu_q.push_back(mk_ifu(32'h8000_0300, 0, -1, 32'h0));
    drain("timeout", 60);
    ifu_q.push_back(mk_ifu(32'h8000_0304, 0, 2, 32'h0000_0093));
    drain("after_timeout", 60);

    // response on the final timeout cycle wins; one cycle later times out
    ifu_q.push_back(mk_ifu(32'h8000_0400, 0, TO - 1, 32'h1234_5678));
    drain("collision", 60);
    lsu_q.push_back(mk_lsu(32'h9000_0400, 1'b0, 32'h0, 4'hF, 0, TO, 32'h8765_4321));
    drain("one_past_timeout", 60);

    // reset while in WAIT: no response for the aborted fetch
    ifu_q.push_back(mk_ifu(32'h8000_0500, 0, -1, 32'h0));
    repeat (5) tick();
    apply_reset();
    repeat (TO + 6) tick();
    ifu_q.push_back(mk_ifu(32'h8000_0504, 0, 1, 32'h0000_0513));
    drain("after_reset", 60);

    // randomized traffic with stray bus responses
    noise_en = 1;
    for (int i = 0; i < 400; i++) begin
      if (ifu_q.size() < 2 && $urandom_range(0, 2) == 0) ifu_q.push_back(rand_req(1'b0));
      if (lsu_q.size() < 2 && $urandom_range(0, 2) == 0) lsu_q.push_back(rand_req(1'b1));
      tick();
    end
    drain("random", 3000);
    noise_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #1000000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
